// File: rtl/cpu_isa_pkg.sv
// Shared CPU ISA constants and the instruction-prefetch FSM state type.
// Opcode occupies the top OPCODE_W bits of every 16-bit instruction word.
package cpu_isa_pkg;

    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned ISA_DW   = 16;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_BZ   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_BR   = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00111;

    localparam logic [ISA_DW-1:0] NOP_WORD = {OP_NOP, 11'b0};

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StDiscard,
        StStopped
    } pf_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of {addr,data} entries with a registered head (NOP when empty).
// Flush beats push and pop; a push into a full FIFO only lands alongside a pop.
module prefetch_fifo
    import cpu_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [AW+DW-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [AW+DW-1:0] head,
    output logic             head_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d, kept;
    logic [AW+DW-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             do_pop, do_push;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign head       = head_q;
    assign head_valid = valid_q;

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        kept    = count_q - CW'(do_pop);
        rptr_d  = rptr_q + PW'(do_pop);
        wptr_d  = wptr_q + PW'(do_push);
        count_d = kept + CW'(do_push);
        head_d  = {{AW{1'b0}}, DW'(NOP_WORD)};
        valid_d = 1'b0;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else if (count_d != '0) begin
            valid_d = 1'b1;
            // Head is either the only entry being written now, or an older stored entry.
            head_d  = (kept == '0) ? wdata : mem_q[rptr_d];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            head_q  <= {{AW{1'b0}}, DW'(NOP_WORD)};
            valid_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            head_q  <= head_d;
            valid_q <= valid_d;
            if (do_push && !flush) begin
                mem_q[wptr_q] <= wdata;
            end
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch front end: req/ack memory fetch into a small FIFO feeding the CPU.
// Define PREFETCH_HALT_STOP_EN to stop fetching after a HALT word is pushed.
module instr_prefetch
    import cpu_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          start,
    input  logic          cpu_consume,
    input  logic          cpu_redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [DW-1:0] i_datain,
    output logic [AW-1:0] i_addr,
    output logic          i_valid,
    output logic          m_req,
    output logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack
);

    pf_state_e     state_q, state_d;
    logic [AW-1:0] fptr_q, fptr_d;
    logic [AW-1:0] redir_q, redir_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic          m_req_q, m_req_d;

    logic             push, pop, flush, full, empty, issue;
    logic [AW+DW-1:0] head;

    assign m_req  = m_req_q;
    assign m_addr = m_addr_q;

    prefetch_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     ({fptr_q, m_rdata}),
        .full      (full),
        .empty     (empty),
        .head      (head),
        .head_valid(i_valid)
    );

    assign i_addr   = head[AW+DW-1:DW];
    assign i_datain = head[DW-1:0];

    always_comb begin
        state_d  = state_q;
        fptr_d   = fptr_q;
        redir_d  = redir_q;
        m_req_d  = m_req_q;
        m_addr_d = m_addr_q;
        push     = 1'b0;
        flush    = 1'b0;
        pop      = cpu_consume & ~cpu_redirect & ~empty;
        // A consume this cycle frees the slot the new request will eventually fill.
        issue    = enable & (~full | cpu_consume);

        unique case (state_q)
            StIdle: begin
                if (cpu_redirect) begin
                    flush   = 1'b1;
                    fptr_d  = redirect_pc;
                    state_d = StFetch;
                end else if (start) begin
                    fptr_d = '0;
                    if (issue) begin
                        m_req_d  = 1'b1;
                        m_addr_d = '0;
                        state_d  = StWait;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (cpu_redirect) begin
                    flush  = 1'b1;
                    fptr_d = redirect_pc;
                end else if (issue) begin
                    m_req_d  = 1'b1;
                    m_addr_d = fptr_q;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    if (cpu_redirect) begin
                        flush   = 1'b1;
                        fptr_d  = redirect_pc;
                        state_d = StFetch;
                    end else begin
                        push    = 1'b1;
                        fptr_d  = fptr_q + 1'b1;
                        state_d = StFetch;
`ifdef PREFETCH_HALT_STOP_EN
                        if (m_rdata[DW-1 -: OPCODE_W] == OP_HALT) begin
                            state_d = StStopped;
                        end
`endif
                    end
                end else if (cpu_redirect) begin
                    flush   = 1'b1;
                    redir_d = redirect_pc;
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (cpu_redirect) begin
                    flush   = 1'b1;
                    redir_d = redirect_pc;
                end
                if (m_ack) begin
                    m_req_d = 1'b0;
                    fptr_d  = cpu_redirect ? redirect_pc : redir_q;
                    state_d = StFetch;
                end
            end
            StStopped: begin
                if (cpu_redirect) begin
                    flush   = 1'b1;
                    fptr_d  = redirect_pc;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            fptr_q   <= '0;
            redir_q  <= '0;
            m_req_q  <= 1'b0;
            m_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            fptr_q   <= fptr_d;
            redir_q  <= redir_d;
            m_req_q  <= m_req_d;
            m_addr_q <= m_addr_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed self-checking bench for instr_prefetch; inputs change and outputs are checked
// on the falling edge. Honours PREFETCH_HALT_STOP_EN for the HALT scenario.
module tb_instr_prefetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic        cpu_consume = 1'b0;
    logic        cpu_redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [15:0] i_datain;
    logic [7:0]  i_addr;
    logic        i_valid;
    logic        m_req;
    logic [7:0]  m_addr;
    logic [15:0] m_rdata = 16'h0000;
    logic        m_ack = 1'b0;

    int checks   = 0;
    int failures = 0;

    instr_prefetch #(
        .DEPTH(4),
        .AW   (8),
        .DW   (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .cpu_consume (cpu_consume),
        .cpu_redirect(cpu_redirect),
        .redirect_pc (redirect_pc),
        .i_datain    (i_datain),
        .i_addr      (i_addr),
        .i_valid     (i_valid),
        .m_req       (m_req),
        .m_addr      (m_addr),
        .m_rdata     (m_rdata),
        .m_ack       (m_ack)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Wait (bounded) for a request, check its address, then ack it for one cycle.
    task automatic serve(input logic [7:0] addr, input logic [15:0] data);
        int n = 0;
        while (m_req !== 1'b1 && n < 8) begin
            @(negedge clock);
            n++;
        end
        chk("serve_req", 32'(m_req), 32'd1);
        chk("serve_addr", 32'(m_addr), 32'(addr));
        m_ack   = 1'b1;
        m_rdata = data;
        @(negedge clock);
        m_ack   = 1'b0;
    endtask

    task automatic no_req(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'(m_req), 32'd0);
            @(negedge clock);
        end
    endtask

    task automatic redirect(input logic [7:0] pc);
        cpu_redirect = 1'b1;
        redirect_pc  = pc;
        @(negedge clock);
        cpu_redirect = 1'b0;
        redirect_pc  = 8'h00;
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("rst_valid", 32'(i_valid), 32'd0);
        chk("rst_data", 32'(i_datain), 32'h0000);
        chk("rst_addr", 32'(i_addr), 32'h00);
        chk("rst_req", 32'(m_req), 32'd0);
        chk("rst_maddr", 32'(m_addr), 32'h00);
        reset = 1'b0;
        cyc(1);
        no_req("idle_req", 2);

        // Start: request one cycle later, sequential fetch 00..03
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_lat", 32'(m_req), 32'd1);
        serve(8'h00, 16'h1000);
        chk("first_valid", 32'(i_valid), 32'd1);
        chk("first_data", 32'(i_datain), 32'h1000);
        chk("first_addr", 32'(i_addr), 32'h00);
        serve(8'h01, 16'h1001);
        serve(8'h02, 16'h1002);
        serve(8'h03, 16'h1003);

        // Full FIFO: no requests until a consume, then exactly one
        no_req("full_noreq", 3);
        chk("full_head", 32'(i_datain), 32'h1000);
        cpu_consume = 1'b1;
        @(negedge clock);
        cpu_consume = 1'b0;
        chk("pop_data", 32'(i_datain), 32'h1001);
        chk("pop_addr", 32'(i_addr), 32'h01);
        chk("refill_req", 32'(m_req), 32'd1);
        chk("refill_addr", 32'(m_addr), 32'h04);
        serve(8'h04, 16'h1004);
        no_req("refill_once", 3);

        // Redirect while a request to 02 is pending: its data is discarded
        redirect(8'h02);
        chk("flush_valid", 32'(i_valid), 32'd0);
        @(negedge clock);
        chk("pend_req", 32'(m_req), 32'd1);
        chk("pend_addr", 32'(m_addr), 32'h02);
        cpu_redirect = 1'b1;
        redirect_pc  = 8'h40;
        @(negedge clock);
        cpu_redirect = 1'b0;
        redirect_pc  = 8'h00;
        cyc(1);
        chk("disc_hold", 32'(m_req), 32'd1);
        chk("disc_addr", 32'(m_addr), 32'h02);
        m_ack   = 1'b1;
        m_rdata = 16'h1002;
        @(negedge clock);
        m_ack = 1'b0;
        chk("disc_drop_req", 32'(m_req), 32'd0);
        chk("disc_drop_valid", 32'(i_valid), 32'd0);
        serve(8'h40, 16'h1040);
        chk("redir_valid", 32'(i_valid), 32'd1);
        chk("redir_addr", 32'(i_addr), 32'h40);
        chk("redir_data", 32'(i_datain), 32'h1040);

        // Address wrap FE, FF, 00
        redirect(8'hFE);
        serve(8'hFE, 16'h10FE);
        chk("wrap_head_addr", 32'(i_addr), 32'hFE);
        chk("wrap_head_data", 32'(i_datain), 32'h10FE);
        serve(8'hFF, 16'h10FF);
        serve(8'h00, 16'h1100);
        chk("wrap_head_keep", 32'(i_addr), 32'hFE);

        // HALT word at 03
        redirect(8'h02);
        serve(8'h02, 16'h1002);
        serve(8'h03, 16'h0800);
        chk("halt_pre_head", 32'(i_datain), 32'h1002);
        cpu_consume = 1'b1;
        @(negedge clock);
        cpu_consume = 1'b0;
        chk("halt_valid", 32'(i_valid), 32'd1);
        chk("halt_data", 32'(i_datain), 32'h0800);
        chk("halt_addr", 32'(i_addr), 32'h03);
`ifdef PREFETCH_HALT_STOP_EN
        no_req("halt_stop", 4);
`else
        serve(8'h04, 16'h1004);
`endif

        // Reset during WAIT, then a late ack is ignored
        redirect(8'h10);
        chk("pre_rst_flush", 32'(i_valid), 32'd0);
        @(negedge clock);
        chk("pre_rst_req", 32'(m_req), 32'd1);
        chk("pre_rst_addr", 32'(m_addr), 32'h10);
        reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(m_req), 32'd0);
        chk("async_rst_maddr", 32'(m_addr), 32'h00);
        @(negedge clock);
        reset   = 1'b0;
        m_ack   = 1'b1;
        m_rdata = 16'hBEEF;
        @(negedge clock);
        m_ack = 1'b0;
        chk("late_valid", 32'(i_valid), 32'd0);
        chk("late_data", 32'(i_datain), 32'h0000);
        chk("late_addr", 32'(i_addr), 32'h00);
        no_req("late_noreq", 2);

        // enable low holds off issue; raising it lets the first request out
        enable = 1'b0;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        no_req("en_low", 3);
        enable = 1'b1;
        @(negedge clock);
        chk("en_high_req", 32'(m_req), 32'd1);
        chk("en_high_addr", 32'(m_addr), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_prefetch.md
Name: instr_prefetch

Overview:
- Instruction-fetch front end sitting directly upstream of the CPU; it supplies the CPU's 16-bit instruction input.
- Fetches words from instruction memory over a req/ack handshake into a small FIFO, ahead of execution.
- Presents the head word and its address to the CPU, pops the head on CPU consume, and flushes on branch redirect.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16)
- AW, 8, instruction address width
- DW, 16, instruction word width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  high allows new memory requests; low freezes issue only
- start  in  1  one-cycle pulse; begins fetching at address 0 from IDLE
- cpu_consume  in  1  CPU has taken the head word; pop it
- cpu_redirect  in  1  branch taken; flush and refetch
- redirect_pc  in  AW  target address, valid with cpu_redirect
- i_datain  out  DW  head instruction; NOP word {NOP,11'b0} when empty
- i_addr  out  AW  address of the head instruction
- i_valid  out  1  head entry valid
- m_req  out  1  memory read request
- m_addr  out  AW  memory read address; stable while m_req is high
- m_rdata  in  DW  memory read data; valid when m_ack is high
- m_ack  in  1  read complete, one-cycle pulse

Behaviour:
- Reset values (asynchronous assert): state IDLE, fptr=0, count=0, m_req=0, m_addr=0, i_valid=0, i_addr=0, i_datain=NOP word.
- Reset mid-transaction: an m_ack arriving after reset is ignored.
- FSM states: IDLE, FETCH, WAIT, DISCARD, STOPPED. At most one request outstanding.
- IDLE:
  - start -> FETCH with fptr=0.
  - cpu_redirect -> FETCH with fptr=redirect_pc.
- FETCH:
  - If enable=1 and (count<DEPTH or cpu_consume this cycle): assert m_req with m_addr=fptr next cycle, go to WAIT.
  - Otherwise stay in FETCH.
- WAIT:
  - Hold m_req and m_addr until m_ack.
  - On m_ack: drop m_req, push {fptr, m_rdata}, fptr<=fptr+1 (wraps 0xFF->0x00), go to FETCH.
- DISCARD (entered on redirect while WAIT):
  - Keep m_req until m_ack; drop the data.
  - Then m_req=0, go to FETCH at the latched redirect_pc.
- Redirect in any state except WAIT: flush the FIFO (count=0, i_valid=0 next cycle), fptr<=redirect_pc, go to FETCH.
- Redirect in the same cycle as m_ack: the data is dropped and the FSM goes directly to FETCH at redirect_pc.
- Priority: reset > cpu_redirect > cpu_consume > push. A consume in a redirect cycle is ignored.
- Pop:
  - cpu_consume with i_valid=1 advances the head.
  - cpu_consume with i_valid=0 is a no-op.
- Full FIFO: push allowed only if a pop occurs in the same cycle; no overflow is possible.
- Latency:
  - start at cycle t -> m_req=1 at t+1.
  - m_ack at cycle u -> i_valid=1, with data and address, at u+1 if the FIFO was empty.
- enable=0: no new request is issued; an outstanding request still completes and is pushed.
- All outputs are registered.

Optional Feature:
- Macro: PREFETCH_HALT_STOP_EN.
- Defined:
  - When a pushed word has opcode [15:11]==HALT, the FSM enters STOPPED and issues no further requests.
  - Only cpu_redirect or reset leaves STOPPED.
  - The HALT word itself is still delivered.
- Undefined:
  - STOPPED is unreachable; fetching continues sequentially past HALT.

Decomposition:
- Package cpu_isa_pkg:
  - opcode width 5 and opcode constants (NOP=5'b00000, HALT=5'b00001, BZ and the others as in the CPU)
  - NOP_WORD
  - prefetch FSM state enum
- Sub-module prefetch_fifo: synchronous FIFO of {addr,data}, DEPTH entries.
  - Ports: push, pop, flush, full, empty, head.
  - Flush has priority over push and pop.

Test Plan:
- Reset then start, memory acks after 1 cycle with word at addr n = 16'h1000+n -> m_addr sequence 00,01,02,03; i_valid rises the cycle after the first ack with i_datain=16'h1000, i_addr=00.
- No consume, 4 words fetched (FIFO full) -> m_req stays 0; one cpu_consume -> exactly one new request, to m_addr=04.
- Redirect to 8'h40 while m_req is pending at addr 02 -> the ack for 02 is discarded; next m_addr=40; first valid word has i_addr=40 and no stale data.
- Start fetching at redirect_pc=8'hFE -> m_addr sequence FE, FF, 00.
- Word at addr 03 = {HALT,11'b0} -> with PREFETCH_HALT_STOP_EN no request above 03 and HALT delivered; without it, fetch continues to 04.
- Reset asserted while in WAIT, then a late m_ack -> outputs at reset values, no push, i_valid=0.
